// File: rtl/apb_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared types and constants for the APB decoder slice.
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

  localparam int APB_PROT_W = 3;

  typedef enum logic [1:0] {
    DEC_IDLE   = 2'd0,
    DEC_ACCESS = 2'd1,
    DEC_ERR    = 2'd2
  } apb_dec_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_if
// Brief    : APB requester/completer bundle with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                          psel;
  logic                          penable;
  logic                          pwrite;
  logic [ADDR_WIDTH-1:0]         paddr;
  logic [apb_pkg::APB_PROT_W-1:0] pprot;
  logic [DATA_WIDTH-1:0]         pwdata;
  logic [DATA_WIDTH/8-1:0]       pstrb;
  logic                          pready;
  logic [DATA_WIDTH-1:0]         prdata;
  logic                          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface
`default_nettype wire

// File: rtl/apb_decoder_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : apb_addr_decode
// Brief    : Combinational base/mask priority decoder, lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module apb_addr_decode #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_SLAVES = 4,
  parameter int                    IDX_W      = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE [NUM_SLAVES] = '{default: '0},
  parameter logic [ADDR_WIDTH-1:0] MASK [NUM_SLAVES] = '{default: '0}
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] onehot
);

  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    onehot = '0;
    // Scan downwards so the lowest matching index is the last one written.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((paddr & MASK[i]) == BASE[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    if (hit) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_decoder.sv
`default_nettype none
// ============================================================================
// Module   : apb_decoder
// Brief    : One-to-many APB stage with unmapped and timeout error responses.
// Revision : 1.0 - initial release
// ============================================================================
module apb_decoder
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_SLAVES     = 4,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE [NUM_SLAVES] =
    '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000},
  parameter logic [ADDR_WIDTH-1:0] SLAVE_MASK [NUM_SLAVES] =
    '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000},
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  apb_if.slave                                 master_if,
  output logic [NUM_SLAVES-1:0]                s_psel,
  output logic                                 s_penable,
  output logic                                 s_pwrite,
  output logic [ADDR_WIDTH-1:0]                s_paddr,
  output logic [APB_PROT_W-1:0]                s_pprot,
  output logic [DATA_WIDTH-1:0]                s_pwdata,
  output logic [DATA_WIDTH/8-1:0]              s_pstrb,
  input  logic [NUM_SLAVES-1:0]                s_pready,
  input  logic [NUM_SLAVES-1:0]                s_pslverr,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] s_prdata,
  output logic                                 err_unmapped,
  output logic                                 err_timeout
);

  localparam int              c_idx_w   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int              c_cnt_w   = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] c_st_idle   = DEC_IDLE;
  localparam logic [1:0] c_st_access = DEC_ACCESS;
  localparam logic [1:0] c_st_err    = DEC_ERR;

  logic [1:0]            r_state;
  logic [c_idx_w-1:0]    r_idx;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_err_unmapped;
  logic                  r_err_timeout;

  logic                  w_hit;
  logic [c_idx_w-1:0]    w_idx;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic                  w_setup;
  logic                  w_timeout;
  logic                  w_slv_done;
  logic                  w_pready;
  logic                  w_pslverr;
  logic [DATA_WIDTH-1:0] w_prdata;

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (c_idx_w),
    .BASE       (SLAVE_BASE),
    .MASK       (SLAVE_MASK)
  ) u_addr_decode (
    .paddr  (master_if.paddr),
    .hit    (w_hit),
    .idx    (w_idx),
    .onehot (w_onehot)
  );

  assign w_setup    = master_if.psel & ~master_if.penable;
  assign w_slv_done = master_if.psel & master_if.penable & s_pready[r_idx];
  assign w_timeout  = (r_state == c_st_access) & master_if.psel & master_if.penable &
                      ~s_pready[r_idx] & (r_cnt == c_cnt_max);

  // Request fields are broadcast; only select and enable are held off in reset.
  assign s_penable = rst_n & master_if.penable;
  assign s_pwrite  = master_if.pwrite;
  assign s_paddr   = master_if.paddr;
  assign s_pprot   = master_if.pprot;
  assign s_pwdata  = master_if.pwdata;
  assign s_pstrb   = master_if.pstrb;

  always_comb begin
    s_psel    = '0;
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    case (r_state)
      c_st_idle: begin
        if (rst_n && w_setup && w_hit) begin
          s_psel = w_onehot;
        end
      end
      c_st_access: begin
        if (master_if.psel && !w_timeout) begin
          s_psel[r_idx] = 1'b1;
        end
        if (w_slv_done) begin
          w_pready  = 1'b1;
          w_pslverr = s_pslverr[r_idx];
          w_prdata  = s_prdata[r_idx];
        end else if (w_timeout) begin
          w_pready  = 1'b1;
          w_pslverr = 1'b1;
        end
      end
      c_st_err: begin
        if (master_if.psel && master_if.penable) begin
          w_pready  = 1'b1;
          w_pslverr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign master_if.pready  = w_pready;
  assign master_if.pslverr = w_pslverr;
  assign master_if.prdata  = w_prdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= c_st_idle;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_err_unmapped <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_err_unmapped <= 1'b0;
      r_err_timeout  <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_setup) begin
            if (w_hit) begin
              r_state <= c_st_access;
              r_idx   <= w_idx;
              r_cnt   <= '0;
            end else begin
              r_state <= c_st_err;
            end
          end
        end
        c_st_access: begin
          if (!master_if.psel || w_slv_done) begin
            r_state <= c_st_idle;
          end else if (w_timeout) begin
            r_state       <= c_st_idle;
            r_err_timeout <= 1'b1;
          end else if (master_if.penable && r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        c_st_err: begin
          if (!master_if.psel) begin
            r_state <= c_st_idle;
          end else if (master_if.penable) begin
            r_state        <= c_st_idle;
            r_err_unmapped <= 1'b1;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign err_unmapped = r_err_unmapped;
  assign err_timeout  = r_err_timeout;

endmodule
`default_nettype wire
